// File: rtl/bru_pkg.sv
// -----------------------------------------------------------------------------
// bru_pkg
// Shared types and helpers for the branch resolve unit.
//   bru_entry_t    : one in-flight prediction as captured at fetch
//   PC_INC         : fall-through PC increment
//   is_mispredict(): compares a queued prediction against the EX outcome
// -----------------------------------------------------------------------------
package bru_pkg;

  localparam int BRU_AW = 32;
  localparam int PC_INC = 4;

  typedef struct packed {
    logic              pred_taken;
    logic [BRU_AW-1:0] pred_addr;
    logic [BRU_AW-1:0] pred_pc;
    logic [BRU_AW-1:0] pred_next_pc;
  } bru_entry_t;

  // A taken branch is also wrong when it went to a different target than the
  // predictor supplied; a not-taken branch only cares about direction.
  function automatic logic is_mispredict(input bru_entry_t        entry,
                                         input logic              taken,
                                         input logic [BRU_AW-1:0] target);
    return (taken != entry.pred_taken) ||
           (taken && (target != entry.pred_addr));
  endfunction

endpackage

// File: rtl/bru_fifo.sv
// -----------------------------------------------------------------------------
// bru_fifo
// Synchronous circular FIFO of bru_entry_t with a clear input.
// Ports:
//   clk, Reset : clock, synchronous active-high reset
//   clear      : empties the queue on this edge, overriding push and pop
//   push, din  : write strobe and entry; dropped when full unless popping
//   pop        : removes the head; ignored when empty
//   head       : oldest entry (valid when !empty)
//   full, empty: decoded from the registered count
// -----------------------------------------------------------------------------
module bru_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  bru_entry_t din,
  output bru_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  bru_entry_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop in the same cycle frees a slot, so a push into a full queue is
  // still accepted when the head is leaving.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: storage is not reset; entries are only observed through the
  // count-guarded head, so clearing the array would just cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (Reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Pairs in-order branch predictions from fetch with EX-stage outcomes, raises a
// one-cycle flush plus corrected PC on mispredict, and returns every actual
// outcome to the predictor as its training input.
// Ports:
//   clk, Reset          : clock, synchronous active-high reset
//   pred_valid/taken/addr/pc/next_pc : prediction push from fetch
//   res_valid/taken/target           : resolution of the oldest branch from EX
//   full, empty         : queue status (fetch stalls pushes on full)
//   flush, redirect_pc  : registered squash pulse and corrected fetch PC
//   update_valid/taken/pc : registered predictor training pulse
//   underflow_err       : sticky, resolve seen with nothing queued
// Optional build macro BRU_STATS_EN adds stat_branches / stat_mispredicts,
// saturating 32-bit counters of accepted resolves and mispredicts.
// -----------------------------------------------------------------------------
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = BRU_AW
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          pred_valid,
  input  logic          pred_taken,
  input  logic [AW-1:0] pred_addr,
  input  logic [AW-1:0] pred_pc,
  input  logic [AW-1:0] pred_next_pc,
  input  logic          res_valid,
  input  logic          res_taken,
  input  logic [AW-1:0] res_target,
  output logic          full,
  output logic          empty,
  output logic          flush,
  output logic [AW-1:0] redirect_pc,
  output logic          update_valid,
  output logic          update_taken,
  output logic [AW-1:0] update_pc,
  output logic          underflow_err
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]   stat_branches,
  output logic [31:0]   stat_mispredicts
`endif
);

  bru_entry_t push_entry;
  bru_entry_t head;
  logic       accept_res;
  logic       mispredict;

  assign push_entry = '{pred_taken:   pred_taken,
                        pred_addr:    pred_addr,
                        pred_pc:      pred_pc,
                        pred_next_pc: pred_next_pc};

  assign accept_res = res_valid && !empty;
  assign mispredict = accept_res && is_mispredict(head, res_taken, res_target);

  // On a mispredict every younger queued entry is wrong-path, so the whole
  // queue is cleared, which also discards any same-cycle push.
  bru_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .Reset (Reset),
    .clear (mispredict),
    .push  (pred_valid),
    .pop   (accept_res),
    .din   (push_entry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (Reset) begin
      flush         <= 1'b0;
      redirect_pc   <= '0;
      update_valid  <= 1'b0;
      update_taken  <= 1'b0;
      update_pc     <= '0;
      underflow_err <= 1'b0;
    end else begin
      flush        <= mispredict;
      update_valid <= accept_res;
      if (accept_res) begin
        update_taken <= res_taken;
        update_pc    <= head.pred_pc;
      end
      if (mispredict) begin
        redirect_pc <= res_taken ? res_target : head.pred_next_pc;
      end
      if (res_valid && empty) begin
        underflow_err <= 1'b1;
      end
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk) begin
    if (Reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (accept_res && (stat_branches != '1)) begin
        stat_branches <= stat_branches + 1'b1;
      end
      if (mispredict && (stat_mispredicts != '1)) begin
        stat_mispredicts <= stat_mispredicts + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed bench for branch_resolve_unit. A reference queue tracks in-flight
// predictions; each cycle the expected registered outputs are pushed to a
// scoreboard before the edge and popped/compared after it. Directed constant
// checks pin the key scenarios independently of the reference queue.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;
  import bru_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk;
  logic          Reset;
  logic          pred_valid;
  logic          pred_taken;
  logic [AW-1:0] pred_addr;
  logic [AW-1:0] pred_pc;
  logic [AW-1:0] pred_next_pc;
  logic          res_valid;
  logic          res_taken;
  logic [AW-1:0] res_target;
  logic          full;
  logic          empty;
  logic          flush;
  logic [AW-1:0] redirect_pc;
  logic          update_valid;
  logic          update_taken;
  logic [AW-1:0] update_pc;
  logic          underflow_err;
`ifdef BRU_STATS_EN
  logic [31:0]   stat_branches;
  logic [31:0]   stat_mispredicts;
`endif

  branch_resolve_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk           (clk),
    .Reset         (Reset),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .pred_addr     (pred_addr),
    .pred_pc       (pred_pc),
    .pred_next_pc  (pred_next_pc),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .res_target    (res_target),
    .full          (full),
    .empty         (empty),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .update_valid  (update_valid),
    .update_taken  (update_taken),
    .update_pc     (update_pc),
    .underflow_err (underflow_err)
`ifdef BRU_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        all_chk;
    logic        flush;
    logic [31:0] redirect;
    logic        uv;
    logic        ut;
    logic [31:0] upc;
    logic        full;
    logic        empty;
    logic        uf;
    logic [31:0] stb;
    logic [31:0] stm;
  } exp_t;

  exp_t        exp_q[$];
  bru_entry_t  m_q[$];
  logic        m_uf;
  logic [31:0] m_stb;
  logic [31:0] m_stm;
  int          n_vec;
  int          n_err;
  int          cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_push(input logic t, input logic [31:0] a, input logic [31:0] pc);
    pred_valid   = 1'b1;
    pred_taken   = t;
    pred_addr    = a;
    pred_pc      = pc;
    pred_next_pc = pc + PC_INC;
  endtask

  task automatic set_res(input logic t, input logic [31:0] tgt);
    res_valid  = 1'b1;
    res_taken  = t;
    res_target = tgt;
  endtask

  // Build expectation from current inputs, clock once, then compare.
  task automatic cycle();
    exp_t       e;
    bru_entry_t h;
    bru_entry_t in_e;
    logic       ok;
    logic       mp;
    logic       was_full;
    e  = '0;
    mp = 1'b0;
    if (Reset) begin
      m_q.delete();
      m_uf  = 1'b0;
      m_stb = '0;
      m_stm = '0;
      e.all_chk = 1'b1;
    end else begin
      ok = res_valid && (m_q.size() != 0);
      if (res_valid && (m_q.size() == 0)) m_uf = 1'b1;
      if (ok) begin
        h  = m_q[0];
        mp = is_mispredict(h, res_taken, res_target);
        e.uv  = 1'b1;
        e.ut  = res_taken;
        e.upc = h.pred_pc;
        if (mp) begin
          e.flush    = 1'b1;
          e.redirect = res_taken ? res_target : h.pred_next_pc;
        end
        if (m_stb != '1) m_stb++;
        if (mp && (m_stm != '1)) m_stm++;
      end
      if (mp) begin
        m_q.delete();
      end else begin
        was_full = (m_q.size() == DEPTH);
        if (ok) void'(m_q.pop_front());
        if (pred_valid && (!was_full || ok)) begin
          in_e = '{pred_taken: pred_taken, pred_addr: pred_addr,
                   pred_pc: pred_pc, pred_next_pc: pred_next_pc};
          m_q.push_back(in_e);
        end
      end
    end
    e.full  = (m_q.size() == DEPTH);
    e.empty = (m_q.size() == 0);
    e.uf    = m_uf;
    e.stb   = m_stb;
    e.stm   = m_stm;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    cyc++;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    Reset      = 1'b0;

    e = exp_q.pop_front();
    check($sformatf("c%0d_flush", cyc), {31'd0, flush}, {31'd0, e.flush});
    check($sformatf("c%0d_update_valid", cyc), {31'd0, update_valid}, {31'd0, e.uv});
    check($sformatf("c%0d_full", cyc), {31'd0, full}, {31'd0, e.full});
    check($sformatf("c%0d_empty", cyc), {31'd0, empty}, {31'd0, e.empty});
    check($sformatf("c%0d_underflow", cyc), {31'd0, underflow_err}, {31'd0, e.uf});
    if (e.uv || e.all_chk) begin
      check($sformatf("c%0d_update_taken", cyc), {31'd0, update_taken}, {31'd0, e.ut});
      check($sformatf("c%0d_update_pc", cyc), update_pc, e.upc);
    end
    if (e.flush || e.all_chk) begin
      check($sformatf("c%0d_redirect_pc", cyc), redirect_pc, e.redirect);
    end
`ifdef BRU_STATS_EN
    check($sformatf("c%0d_stat_branches", cyc), stat_branches, e.stb);
    check($sformatf("c%0d_stat_mispredicts", cyc), stat_mispredicts, e.stm);
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    m_uf  = 1'b0;
    m_stb = '0;
    m_stm = '0;
    pred_valid = 1'b0; pred_taken = 1'b0; pred_addr = '0; pred_pc = '0; pred_next_pc = '0;
    res_valid  = 1'b0; res_taken  = 1'b0; res_target = '0;

    // Reset state
    Reset = 1'b1;
    cycle();
    check("rst_empty", {31'd0, empty}, 32'd1);

    // Correct taken prediction
    set_push(1'b1, 32'h100, 32'h40);
    cycle();
    set_res(1'b1, 32'h100);
    cycle();
    check("tp1_update_valid", {31'd0, update_valid}, 32'd1);
    check("tp1_update_taken", {31'd0, update_taken}, 32'd1);
    check("tp1_update_pc", update_pc, 32'h40);
    check("tp1_flush", {31'd0, flush}, 32'd0);
    check("tp1_empty", {31'd0, empty}, 32'd1);

    // Predicted not-taken, actually taken
    set_push(1'b0, 32'h0, 32'h80);
    cycle();
    set_res(1'b1, 32'h200);
    cycle();
    check("tp2_flush", {31'd0, flush}, 32'd1);
    check("tp2_redirect", redirect_pc, 32'h200);
    check("tp2_update_taken", {31'd0, update_taken}, 32'd1);

    // Predicted taken, actually not-taken -> fall-through
    set_push(1'b1, 32'h300, 32'h60);
    cycle();
    set_res(1'b0, 32'h300);
    cycle();
    check("tp3_flush", {31'd0, flush}, 32'd1);
    check("tp3_redirect", redirect_pc, 32'h64);

    // Taken but wrong target
    set_push(1'b1, 32'h300, 32'ha0);
    cycle();
    set_res(1'b1, 32'h304);
    cycle();
    check("tp4_flush", {31'd0, flush}, 32'd1);
    check("tp4_redirect", redirect_pc, 32'h304);
    cycle();
    check("tp4_flush_pulse", {31'd0, flush}, 32'd0);

    // Fill queue, overflow drop, push+pop while full, mispredict clear
    for (int i = 0; i < DEPTH; i++) begin
      set_push(1'b1, 32'h1000 + 32'(i) * 32'h10, 32'h2000 + 32'(i) * 32'h8);
      cycle();
    end
    check("fill_full", {31'd0, full}, 32'd1);
    set_push(1'b0, 32'h0, 32'h3000);
    cycle();
    check("overflow_full", {31'd0, full}, 32'd1);
    set_push(1'b1, 32'h3100, 32'h3100);
    set_res(1'b1, 32'h1000);
    cycle();
    check("pushpop_full", {31'd0, full}, 32'd1);
    check("pushpop_flush", {31'd0, flush}, 32'd0);
    check("pushpop_upc", update_pc, 32'h2000);
    set_push(1'b1, 32'h3200, 32'h3200);
    set_res(1'b0, 32'h0);
    cycle();
    check("clear_flush", {31'd0, flush}, 32'd1);
    check("clear_redirect", redirect_pc, 32'h200c);
    check("clear_empty", {31'd0, empty}, 32'd1);
    cycle();
    check("clear_stays_empty", {31'd0, empty}, 32'd1);

    // Resolve while empty
    set_res(1'b1, 32'h500);
    cycle();
    check("uf_set", {31'd0, underflow_err}, 32'd1);
    check("uf_no_update", {31'd0, update_valid}, 32'd0);
    check("uf_no_flush", {31'd0, flush}, 32'd0);
    cycle();
    check("uf_held", {31'd0, underflow_err}, 32'd1);

    // Reset mid-stream with a mispredict pending
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 32'h4000 + 32'(i) * 32'h10, 32'h5000 + 32'(i) * 32'h8);
      cycle();
    end
    set_res(1'b0, 32'h0);
    Reset = 1'b1;
    cycle();
    check("mrst_flush", {31'd0, flush}, 32'd0);
    check("mrst_update_valid", {31'd0, update_valid}, 32'd0);
    check("mrst_empty", {31'd0, empty}, 32'd1);
    check("mrst_underflow", {31'd0, underflow_err}, 32'd0);

    // Three resolves, one mispredict
    set_push(1'b1, 32'h600, 32'h10);
    cycle();
    set_res(1'b1, 32'h600);
    set_push(1'b0, 32'h0, 32'h20);
    cycle();
    set_res(1'b0, 32'h0);
    set_push(1'b1, 32'h700, 32'h30);
    cycle();
    set_res(1'b0, 32'h0);
    cycle();
    check("stats_last_flush", {31'd0, flush}, 32'd1);
    check("stats_last_redirect", redirect_pc, 32'h34);
`ifdef BRU_STATS_EN
    check("stats_branches", stat_branches, 32'd3);
    check("stats_mispredicts", stat_mispredicts, 32'd1);
`endif
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Consumer end of the dynamic predictor interface. Queues each branch prediction issued at fetch, pairs it in order with the branch outcome computed in EX, and detects mispredictions. On a misprediction it drives a one-cycle flush plus the corrected PC, and in every case returns the actual outcome to the predictor as its branchTaken training input. Sits between the predictor/fetch stage and the EX-stage branch comparator.

Parameters:
DEPTH, 4, in-flight prediction queue entries (power of 2, >=2)
AW, 32, address width

Ports:
clk  in  1  clock; all state updates on posedge
Reset  in  1  synchronous, active-high reset
pred_valid  in  1  push strobe: a predicted branch left fetch this cycle
pred_taken  in  1  predictor's prediction bit
pred_addr  in  AW  predictor's predicted_address
pred_pc  in  AW  PC of the branch
pred_next_pc  in  AW  fall-through PC (PC+4)
res_valid  in  1  EX resolved the oldest in-flight branch this cycle
res_taken  in  1  actual outcome
res_target  in  AW  actual branch target
full  out  1  queue full; fetch must stall prediction pushes
empty  out  1  queue empty
flush  out  1  one-cycle pulse: squash younger instructions
redirect_pc  out  AW  corrected fetch PC, valid while flush=1
update_valid  out  1  one-cycle pulse: predictor training strobe
update_taken  out  1  actual outcome for the predictor (its branchTaken)
update_pc  out  AW  PC of the resolved branch
underflow_err  out  1  sticky: res_valid was seen while the queue was empty

Behaviour:
- Reset (synchronous): pointers and count = 0. full=0, empty=1, flush=0, redirect_pc=0, update_valid=0, update_taken=0, update_pc=0, underflow_err=0.
- Queue: circular FIFO of {pred_taken, pred_addr, pred_pc, pred_next_pc}. Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Push: when pred_valid && !full, write the entry at the tail. Push while full: entry dropped, no state change.
- Resolve: when res_valid && !empty, pop the head.
  - mispredict = (res_taken != head.pred_taken) || (res_taken && res_target != head.pred_addr).
- Registered outputs, one cycle after res_valid:
  - update_valid=1, update_taken=res_taken, update_pc=head.pred_pc.
  - On mispredict: flush=1, redirect_pc = res_taken ? res_target : head.pred_next_pc.
  - flush and update_valid are single-cycle pulses.
- On mispredict, all remaining entries are wrong-path: the queue is cleared in the same edge (count=0, tail=head=0). A push in that same cycle is discarded.
- Simultaneous push and correct resolve: both take effect and count is unchanged. This is legal when full (pop frees a slot, so the push is accepted).
- res_valid while empty: ignored, no pulses, underflow_err set and held until Reset.
- full/empty derive from the registered count and are valid in the same cycle.
- Reset asserted mid-operation overrides everything, including a pending flush pulse.

Optional Feature:
- Macro: BRU_STATS_EN.
- Defined: adds two 32-bit outputs, stat_branches and stat_mispredicts.
  - stat_branches increments on each accepted resolve; stat_mispredicts on each mispredict.
  - Both saturate at all-ones and clear on Reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package bru_pkg holds:
  - typedef bru_entry_t (pred_taken, pred_addr, pred_pc, pred_next_pc);
  - localparam PC_INC = 4;
  - a function is_mispredict(entry, taken, target) reused by the bench scoreboard.
- One natural sub-module: bru_fifo, a parameterized synchronous FIFO with a clear input, holding bru_entry_t. The top level holds the compare logic, output registers and stats.

Test Plan:
- Reset then push {taken=1, addr=0x100, pc=0x40, next=0x44}; resolve taken=1, target=0x100 -> next cycle update_valid=1, update_taken=1, update_pc=0x40, flush=0, empty=1.
- Push {taken=0, pc=0x80, next=0x84}; resolve taken=1, target=0x200 -> flush=1, redirect_pc=0x200, update_taken=1.
- Push {taken=1, addr=0x300, next=0x64}; resolve taken=0 -> flush=1, redirect_pc=0x64.
- Push {taken=1, addr=0x300}; resolve taken=1, target=0x304 -> flush=1, redirect_pc=0x304 (wrong-target case).
- Push 4 entries -> full=1; a 5th push is dropped. Push and correct resolve in the same cycle -> count stays 4. Mispredict on the head -> queue cleared, empty=1 next cycle, and the same-cycle push is discarded.
- Resolve on an empty queue -> no pulses, underflow_err=1 held. Assert Reset mid-stream with 3 entries queued -> all outputs at reset values next cycle.
- With BRU_STATS_EN defined, resolve 3 branches with 1 mispredict -> stat_branches=3, stat_mispredicts=1.
